// File: rtl/hazard_unit_pkg.sv
// Shared opcode/funct codes, Tuse/Tnew constants and forward-select encodings
// for the hazard unit and the datapath forward muxes.
package hazard_unit_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [1:0] TUSE_0 = 2'd0;
  localparam logic [1:0] TUSE_1 = 2'd1;
  localparam logic [1:0] TUSE_2 = 2'd2;
  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;

  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_E   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;
  localparam logic [1:0] FWD_W   = 2'd3;

  typedef enum logic [3:0] {
    I_NOP, I_ADDU, I_SUBU, I_ORI, I_LUI,
    I_LW, I_SW, I_BEQ, I_JAL, I_JR
  } instr_e;

  function automatic instr_e classify(
    input logic [5:0] op,
    input logic [5:0] func
  );
    instr_e k;
    k = I_NOP;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADDU: k = I_ADDU;
          FN_SUBU: k = I_SUBU;
          FN_JR:   k = I_JR;
          default: k = I_NOP;
        endcase
      end
      OP_ORI:  k = I_ORI;
      OP_LUI:  k = I_LUI;
      OP_LW:   k = I_LW;
      OP_SW:   k = I_SW;
      OP_BEQ:  k = I_BEQ;
      OP_JAL:  k = I_JAL;
      default: k = I_NOP;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// D-stage instruction fields in, stall and forward selects out.
// stall_cnt carries the stall counter when HAZARD_STALL_CNT_EN is defined.
interface hazard_unit_if;
  logic [5:0]  op_D;
  logic [5:0]  func_D;
  logic [4:0]  rs_D;
  logic [4:0]  rt_D;
  logic [4:0]  rd_D;
  logic        stall;
  logic [1:0]  fwd_rs_D;
  logic [1:0]  fwd_rt_D;
  logic [1:0]  fwd_rs_E;
  logic [1:0]  fwd_rt_E;
  logic [31:0] stall_cnt;

  modport master (
    output op_D, func_D, rs_D, rt_D, rd_D,
    input  stall, fwd_rs_D, fwd_rt_D,
    input  fwd_rs_E, fwd_rt_E, stall_cnt
  );

  modport slave (
    input  op_D, func_D, rs_D, rt_D, rd_D,
    output stall, fwd_rs_D, fwd_rt_D,
    output fwd_rs_E, fwd_rt_E, stall_cnt
  );
endinterface

// File: rtl/hazard_unit_slot.sv
// One scoreboard writer slot: dest reg, Tnew, RegWr.
// DEC=1 slots age the incoming Tnew by one, saturating at zero.
module hz_slot #(
  parameter int AW  = 5,
  parameter int TW  = 2,
  parameter bit DEC = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] a3_in,
  input  logic [TW-1:0] tnew_in,
  input  logic          wr_in,
  output logic [AW-1:0] a3,
  output logic [TW-1:0] tnew,
  output logic          wr
);
  logic [TW-1:0] tnew_nx;

  assign tnew_nx = (DEC && tnew_in != '0)
                 ? tnew_in - TW'(1)
                 : tnew_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a3   <= '0;
      tnew <= '0;
      wr   <= 1'b0;
    end else begin
      a3   <= a3_in;
      tnew <= tnew_nx;
      wr   <= wr_in;
    end
  end
endmodule

// File: rtl/hazard_unit.sv
// Tnew/Tuse hazard unit: stall plus D/E forward selects from an E/M/W scoreboard.
// Optional HAZARD_STALL_CNT_EN adds a 32-bit stall cycle counter.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int TNEW_W = 2,
  parameter int RA_REG = 31
) (
  input logic         clk,
  input logic         reset,
  hazard_unit_if.slave hz
);
  typedef logic [REG_AW-1:0] reg_t;
  typedef logic [TNEW_W-1:0] tn_t;

  instr_e ins;
  reg_t   a3_d, rs_d, rt_d;
  tn_t    tnew_d, tuse_rs, tuse_rt;
  logic   wr_d;
  logic   stall;

  assign ins = classify(hz.op_D, hz.func_D);

  always_comb begin
    a3_d    = '0;
    rs_d    = '0;
    rt_d    = '0;
    tnew_d  = '0;
    tuse_rs = '0;
    tuse_rt = '0;
    wr_d    = 1'b0;
    unique case (ins)
      I_ADDU, I_SUBU: begin
        a3_d    = reg_t'(hz.rd_D);
        rs_d    = reg_t'(hz.rs_D);
        rt_d    = reg_t'(hz.rt_D);
        tuse_rs = tn_t'(TUSE_1);
        tuse_rt = tn_t'(TUSE_1);
        tnew_d  = tn_t'(TNEW_1);
        wr_d    = 1'b1;
      end
      I_ORI: begin
        a3_d    = reg_t'(hz.rt_D);
        rs_d    = reg_t'(hz.rs_D);
        tuse_rs = tn_t'(TUSE_1);
        tnew_d  = tn_t'(TNEW_1);
        wr_d    = 1'b1;
      end
      I_LUI: begin
        a3_d   = reg_t'(hz.rt_D);
        tnew_d = tn_t'(TNEW_1);
        wr_d   = 1'b1;
      end
      I_LW: begin
        a3_d    = reg_t'(hz.rt_D);
        rs_d    = reg_t'(hz.rs_D);
        tuse_rs = tn_t'(TUSE_1);
        tnew_d  = tn_t'(TNEW_2);
        wr_d    = 1'b1;
      end
      I_SW: begin
        rs_d    = reg_t'(hz.rs_D);
        rt_d    = reg_t'(hz.rt_D);
        tuse_rs = tn_t'(TUSE_1);
        tuse_rt = tn_t'(TUSE_2);
      end
      I_BEQ: begin
        rs_d    = reg_t'(hz.rs_D);
        rt_d    = reg_t'(hz.rt_D);
        tuse_rs = tn_t'(TUSE_0);
        tuse_rt = tn_t'(TUSE_0);
      end
      I_JR: begin
        rs_d    = reg_t'(hz.rs_D);
        tuse_rs = tn_t'(TUSE_0);
      end
      I_JAL: begin
        a3_d   = reg_t'(RA_REG);
        tnew_d = tn_t'(TNEW_0);
        wr_d   = 1'b1;
      end
      default: ;
    endcase
  end

  reg_t e_a3, m_a3, w_a3, e_rs, e_rt;
  tn_t  e_tn, m_tn, w_tn;
  logic e_wr, m_wr, w_wr;

  // A stalled D instruction enters E as a bubble.
  hz_slot #(.AW(REG_AW), .TW(TNEW_W), .DEC(1'b0)) u_e (
    .clk(clk), .reset(reset),
    .a3_in(stall ? '0 : a3_d),
    .tnew_in(stall ? '0 : tnew_d),
    .wr_in(wr_d && !stall),
    .a3(e_a3), .tnew(e_tn), .wr(e_wr)
  );

  hz_slot #(.AW(REG_AW), .TW(TNEW_W), .DEC(1'b1)) u_m (
    .clk(clk), .reset(reset),
    .a3_in(e_a3), .tnew_in(e_tn), .wr_in(e_wr),
    .a3(m_a3), .tnew(m_tn), .wr(m_wr)
  );

  hz_slot #(.AW(REG_AW), .TW(TNEW_W), .DEC(1'b1)) u_w (
    .clk(clk), .reset(reset),
    .a3_in(m_a3), .tnew_in(m_tn), .wr_in(m_wr),
    .a3(w_a3), .tnew(w_tn), .wr(w_wr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_rs <= '0;
      e_rt <= '0;
    end else begin
      e_rs <= stall ? '0 : rs_d;
      e_rt <= stall ? '0 : rt_d;
    end
  end

  function automatic logic hit(
    input logic wr, input reg_t a3, input reg_t src
  );
    return wr && (a3 != '0) && (a3 == src);
  endfunction

  function automatic logic [1:0] pick(
    input logic e, input logic m, input logic w
  );
    if (e)      return FWD_E;
    else if (m) return FWD_M;
    else if (w) return FWD_W;
    else        return FWD_GRF;
  endfunction

  logic he_rs, he_rt, hm_rs, hm_rt, hw_rs, hw_rt;
  logic xm_rs, xm_rt, xw_rs, xw_rt;

  assign he_rs = hit(e_wr, e_a3, rs_d);
  assign he_rt = hit(e_wr, e_a3, rt_d);
  assign hm_rs = hit(m_wr, m_a3, rs_d);
  assign hm_rt = hit(m_wr, m_a3, rt_d);
  assign hw_rs = hit(w_wr, w_a3, rs_d);
  assign hw_rt = hit(w_wr, w_a3, rt_d);
  assign xm_rs = hit(m_wr, m_a3, e_rs);
  assign xm_rt = hit(m_wr, m_a3, e_rt);
  assign xw_rs = hit(w_wr, w_a3, e_rs);
  assign xw_rt = hit(w_wr, w_a3, e_rt);

  assign stall = (he_rs && e_tn > tuse_rs)
              || (he_rt && e_tn > tuse_rt)
              || (hm_rs && m_tn > tuse_rs)
              || (hm_rt && m_tn > tuse_rt);

  assign hz.stall    = stall;
  assign hz.fwd_rs_D = pick(he_rs && e_tn == '0,
                            hm_rs && m_tn == '0,
                            hw_rs && w_tn == '0);
  assign hz.fwd_rt_D = pick(he_rt && e_tn == '0,
                            hm_rt && m_tn == '0,
                            hw_rt && w_tn == '0);
  assign hz.fwd_rs_E = pick(1'b0,
                            xm_rs && m_tn == '0,
                            xw_rs && w_tn == '0);
  assign hz.fwd_rt_E = pick(1'b0,
                            xm_rt && m_tn == '0,
                            xw_rt && w_tn == '0);

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      cnt <= '0;
    else if (stall) cnt <= cnt + 32'd1;
  end

  assign hz.stall_cnt = cnt;
`else
  assign hz.stall_cnt = '0;
`endif

endmodule
